// File: rtl/remote_comm_if.sv
`default_nettype none
// ============================================================================
// Module      : remote_comm_if
// Description : Host-side command/response bundle for remote_comm.
// Revision    : 1.0 - initial release
// ============================================================================
interface remote_comm_if;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        send_cmd;
    logic        cmd_sent;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_resp_rdy;

    modport master (
        output cmd, data, send_cmd, clr_resp_rdy,
        input  cmd_sent, resp, resp_rdy
    );

    modport slave (
        input  cmd, data, send_cmd, clr_resp_rdy,
        output cmd_sent, resp, resp_rdy
    );
endinterface
`default_nettype wire

// File: rtl/remote_comm.sv
`default_nettype none
// ============================================================================
// Module      : remote_comm
// Description : 8N1 UART link: sends a 3-byte command frame, receives responses.
// Revision    : 1.0 - initial release
// ============================================================================
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         RX,
    output logic         TX,
    remote_comm_if.slave host
);
    localparam int c_tx_w = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int c_rx_w = $clog2(BAUD_DIV + BAUD_DIV / 2 + 1);
    localparam logic [c_tx_w-1:0] c_tx_last  = c_tx_w'(BAUD_DIV - 1);
    localparam logic [c_rx_w-1:0] c_rx_first = c_rx_w'(BAUD_DIV + BAUD_DIV / 2 - 1);
    localparam logic [c_rx_w-1:0] c_rx_bit   = c_rx_w'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } seq_state_e;

    seq_state_e        state_q, state_d;
    logic [15:0]       data_q, data_d;
    logic [8:0]        tx_shift_q, tx_shift_d;
    logic [c_tx_w-1:0] tx_baud_q, tx_baud_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic              tx_q, tx_d;
    logic              cmd_sent_q, cmd_sent_d;

    logic              rx_meta_q, rx_meta_d;
    logic              rx_sync_q, rx_sync_d;
    logic              rx_busy_q, rx_busy_d;
    logic [c_rx_w-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [7:0]        resp_q, resp_d;
    logic              resp_rdy_q, resp_rdy_d;

    // Transmit sequencer: bit 0 is the start bit, 1..8 data, 9 the stop bit.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        tx_shift_d = tx_shift_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        cmd_sent_d = cmd_sent_q;
        if (state_q == IDLE) begin
            if (host.send_cmd) begin
                state_d    = CMD;
                data_d     = host.data;
                tx_shift_d = {1'b1, host.cmd};
                tx_baud_d  = '0;
                tx_bit_d   = 4'd0;
                tx_d       = 1'b0;
                cmd_sent_d = 1'b0;
            end
        end else if (tx_baud_q == c_tx_last) begin
            tx_baud_d = '0;
            if (tx_bit_q == 4'd9) begin
                tx_bit_d = 4'd0;
                tx_d     = 1'b0;
                case (state_q)
                    CMD: begin
                        state_d    = HIGH;
                        tx_shift_d = {1'b1, data_q[15:8]};
                    end
                    HIGH: begin
                        state_d    = LOW;
                        tx_shift_d = {1'b1, data_q[7:0]};
                    end
                    default: begin
                        state_d    = IDLE;
                        tx_d       = 1'b1;
                        cmd_sent_d = 1'b1;
                    end
                endcase
            end else begin
                tx_bit_d   = tx_bit_q + 4'd1;
                tx_d       = tx_shift_q[0];
                tx_shift_d = {1'b1, tx_shift_q[8:1]};
            end
        end else begin
            tx_baud_d = tx_baud_q + 1'b1;
        end
    end

    // Receiver: first sample lands mid-bit-0, the ninth sample is the stop bit.
    always_comb begin
        rx_meta_d  = RX;
        rx_sync_d  = rx_meta_q;
        rx_busy_d  = rx_busy_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        resp_d     = resp_q;
        resp_rdy_d = host.clr_resp_rdy ? 1'b0 : resp_rdy_q;
        if (!rx_busy_q) begin
            if (!rx_sync_q) begin
                rx_busy_d  = 1'b1;
                rx_cnt_d   = c_rx_first;
                rx_bit_d   = 4'd0;
                resp_rdy_d = 1'b0;
            end
        end else if (rx_cnt_q == '0) begin
            rx_cnt_d = c_rx_bit;
            if (rx_bit_q == 4'd8) begin
                rx_busy_d  = 1'b0;
                resp_d     = rx_shift_q;
                resp_rdy_d = 1'b1;
            end else begin
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
            end
        end else begin
            rx_cnt_d = rx_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            cmd_sent_q <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            tx_shift_q <= tx_shift_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            cmd_sent_q <= cmd_sent_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_busy_q  <= rx_busy_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

    assign TX            = tx_q;
    assign host.cmd_sent = cmd_sent_q;
    assign host.resp     = resp_q;
    assign host.resp_rdy = resp_rdy_q;
endmodule
`default_nettype wire

// File: tb/tb_remote_comm.sv
`default_nettype none
// ============================================================================
// Module      : tb_remote_comm
// Description : Directed self-checking bench for remote_comm at BAUD_DIV=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_remote_comm;
    localparam int c_baud = 16;

    logic clk;
    logic rst_n;
    logic rx_line;
    logic tx_line;
    int   checks;
    int   errors;
    logic [7:0] tx_bytes[$];

    remote_comm_if bus ();

    remote_comm #(.BAUD_DIV(c_baud)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (rx_line),
        .TX    (tx_line),
        .host  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback decoder: samples each TX bit at its midpoint.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_line === 1'b0) begin
                repeat (c_baud / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (c_baud) @(negedge clk);
                    b[i] = tx_line;
                end
                repeat (c_baud) @(negedge clk);
                tx_bytes.push_back(b);
            end
        end
    end

    task automatic drive_rx(input logic [7:0] b);
        rx_line = 1'b0;
        repeat (c_baud) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (c_baud) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (c_baud) @(negedge clk);
    endtask

    task automatic pulse_send(input logic [7:0] c, input logic [15:0] d);
        @(negedge clk);
        bus.cmd      = c;
        bus.data     = d;
        bus.send_cmd = 1'b1;
        @(negedge clk);
        bus.send_cmd = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_line); end
        checks++; if (bus.cmd_sent !== 1'b0) begin errors++; $display("FAIL reset_cmd_sent got %b want 0", bus.cmd_sent); end
        checks++; if (bus.resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy got %b want 0", bus.resp_rdy); end
        checks++; if (bus.resp !== 8'h00) begin errors++; $display("FAIL reset_resp got %h want 00", bus.resp); end
    endtask

    task automatic test_send;
        int n;
        logic [7:0] exp [3];
        exp = '{8'h05, 8'h00, 8'hFF};
        tx_bytes.delete();
        pulse_send(8'h05, 16'h00FF);
        checks++; if (bus.cmd_sent !== 1'b0) begin errors++; $display("FAIL send_cmd_sent_clr got %b want 0", bus.cmd_sent); end
        @(negedge clk);
        checks++; if (tx_line !== 1'b0) begin errors++; $display("FAIL send_start_bit got %b want 0", tx_line); end
        n = 1;
        while (bus.cmd_sent !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n < 478 || n > 482) begin errors++; $display("FAIL send_latency got %0d want 480", n); end
        repeat (20) @(negedge clk);
        checks++; if (bus.cmd_sent !== 1'b1) begin errors++; $display("FAIL send_cmd_sent_hold got %b want 1", bus.cmd_sent); end
        checks++; if (tx_bytes.size() != 3) begin errors++; $display("FAIL send_count got %0d want 3", tx_bytes.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_bytes[i] !== exp[i]) begin errors++; $display("FAIL send_byte%0d got %h want %h", i, tx_bytes[i], exp[i]); end
        end
    endtask

    task automatic test_ignore_resend;
        int n;
        logic [7:0] exp [3];
        exp = '{8'h02, 8'h01, 8'h00};
        tx_bytes.delete();
        pulse_send(8'h02, 16'h0100);
        n = 0;
        while (bus.cmd_sent !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            if (n == 100) begin
                bus.cmd      = 8'hFF;
                bus.data     = 16'hFFFF;
                bus.send_cmd = 1'b1;
            end else if (n == 101) begin
                bus.send_cmd = 1'b0;
            end
        end
        checks++; if (n < 478 || n > 482) begin errors++; $display("FAIL ignore_latency got %0d want 480", n); end
        repeat (200) @(negedge clk);
        checks++; if (tx_bytes.size() != 3) begin errors++; $display("FAIL ignore_count got %0d want 3", tx_bytes.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_bytes[i] !== exp[i]) begin errors++; $display("FAIL ignore_byte%0d got %h want %h", i, tx_bytes[i], exp[i]); end
        end
        checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL ignore_tx_idle got %b want 1", tx_line); end
    endtask

    task automatic test_receive;
        @(negedge clk);
        drive_rx(8'hA5);
        checks++; if (bus.resp !== 8'hA5) begin errors++; $display("FAIL rx_resp got %h want a5", bus.resp); end
        checks++; if (bus.resp_rdy !== 1'b1) begin errors++; $display("FAIL rx_resp_rdy got %b want 1", bus.resp_rdy); end
        bus.clr_resp_rdy = 1'b1;
        @(negedge clk);
        bus.clr_resp_rdy = 1'b0;
        checks++; if (bus.resp_rdy !== 1'b0) begin errors++; $display("FAIL rx_clr got %b want 0", bus.resp_rdy); end
        checks++; if (bus.resp !== 8'hA5) begin errors++; $display("FAIL rx_resp_hold got %h want a5", bus.resp); end
    endtask

    // Clear lands on the same edge the byte completes; the set must win.
    task automatic test_clr_collision;
        @(negedge clk);
        fork
            drive_rx(8'h3C);
            begin
                repeat (154) @(negedge clk);
                bus.clr_resp_rdy = 1'b1;
                @(negedge clk);
                bus.clr_resp_rdy = 1'b0;
                checks++; if (bus.resp_rdy !== 1'b1) begin errors++; $display("FAIL collide_rdy got %b want 1", bus.resp_rdy); end
                checks++; if (bus.resp !== 8'h3C) begin errors++; $display("FAIL collide_resp got %h want 3c", bus.resp); end
            end
        join
    endtask

    task automatic test_full_duplex;
        int n;
        logic [7:0] exp [3];
        exp = '{8'h06, 8'h12, 8'h34};
        tx_bytes.delete();
        @(negedge clk);
        fork
            drive_rx(8'h0A);
            begin
                repeat (5) @(negedge clk);
                checks++; if (bus.resp_rdy !== 1'b0) begin errors++; $display("FAIL duplex_start_clr got %b want 0", bus.resp_rdy); end
            end
            begin
                pulse_send(8'h06, 16'h1234);
                n = 0;
                while (bus.cmd_sent !== 1'b1 && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                checks++; if (n < 478 || n > 482) begin errors++; $display("FAIL duplex_latency got %0d want 480", n); end
            end
        join
        checks++; if (bus.resp !== 8'h0A || bus.resp_rdy !== 1'b1) begin
            errors++; $display("FAIL duplex_resp got %h/%b want 0a/1", bus.resp, bus.resp_rdy);
        end
        checks++; if (tx_bytes.size() != 3) begin errors++; $display("FAIL duplex_count got %0d want 3", tx_bytes.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_bytes[i] !== exp[i]) begin errors++; $display("FAIL duplex_byte%0d got %h want %h", i, tx_bytes[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid_frame;
        int lows;
        tx_bytes.delete();
        pulse_send(8'h5A, 16'hC33C);
        repeat (240) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b want 1", tx_line); end
        checks++; if (bus.cmd_sent !== 1'b0) begin errors++; $display("FAIL midrst_cmd_sent got %b want 0", bus.cmd_sent); end
        checks++; if (bus.resp_rdy !== 1'b0 || bus.resp !== 8'h00) begin
            errors++; $display("FAIL midrst_resp got %h/%b want 00/0", bus.resp, bus.resp_rdy);
        end
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_line !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL midrst_tx_quiet got %0d low cycles want 0", lows); end
        checks++; if (tx_bytes[0] !== 8'h5A) begin errors++; $display("FAIL midrst_first_byte got %h want 5a", tx_bytes[0]); end
        checks++; if (bus.cmd_sent !== 1'b0) begin errors++; $display("FAIL midrst_cmd_sent_hold got %b want 0", bus.cmd_sent); end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        rx_line          = 1'b1;
        bus.cmd          = 8'h00;
        bus.data         = 16'h0000;
        bus.send_cmd     = 1'b0;
        bus.clr_resp_rdy = 1'b0;
        test_reset();
        test_send();
        test_ignore_resend();
        test_receive();
        test_clr_collision();
        test_full_duplex();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/remote_comm.md
REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset named clk and rst_n.
REQ-002 The block SHALL have parameter BAUD_DIV, default 2604, giving the number of clk cycles per UART bit (19200 baud at 50 MHz).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 RX  input  1  serial data from the remote DUT; asynchronous to clk.
REQ-006 TX  output  1  serial data to the remote DUT; idles high.
REQ-007 cmd  input  8  command byte to send.
REQ-008 data  input  16  data word that accompanies the command.
REQ-009 send_cmd  input  1  one-cycle pulse that starts a 3-byte transmission.
REQ-010 cmd_sent  output  1  level; high once all 3 bytes have finished transmitting.
REQ-011 resp  output  8  last response byte received on RX.
REQ-012 resp_rdy  output  1  level; high while resp holds a new, unacknowledged byte.
REQ-013 clr_resp_rdy  input  1  pulse that clears resp_rdy.

Function
REQ-014 UART frame SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, each bit exactly BAUD_DIV clocks.
REQ-015 On send_cmd while idle, cmd and data SHALL be latched in the same cycle; later changes to the inputs SHALL NOT affect the frame.
REQ-016 The byte order SHALL be cmd, then data[15:8], then data[7:0], sent back-to-back with no idle bits between frames.
REQ-017 The sequencer SHALL use states IDLE -> CMD -> HIGH -> LOW -> IDLE, advancing when the transmitter's stop bit completes.
REQ-018 TX SHALL drive the start bit of the cmd byte no later than 2 clk cycles after the send_cmd pulse.
REQ-019 cmd_sent SHALL be cleared in the cycle after send_cmd is accepted.
REQ-020 cmd_sent SHALL be set in the cycle the LOW byte's stop bit ends, and SHALL stay high until the next accepted send_cmd.
REQ-021 send_cmd asserted while not in IDLE SHALL be ignored; the transmission in progress continues unaffected.
REQ-022 RX SHALL be double-flopped before use.
REQ-023 A start condition SHALL be the synchronized RX falling to 0 while the receiver is idle.
REQ-024 The receiver SHALL sample each bit at its midpoint: the first data sample at 1.5*BAUD_DIV clocks after the start edge, then every BAUD_DIV clocks.
REQ-025 The stop bit SHALL be sampled but not checked.
REQ-026 When a byte completes, resp SHALL be loaded and resp_rdy set in the same cycle.
REQ-027 resp SHALL hold its value until the next byte completes.
REQ-028 clr_resp_rdy SHALL clear resp_rdy on the next edge.
REQ-029 If clr_resp_rdy and byte completion occur in the same cycle, resp_rdy SHALL end up set.
REQ-030 Detection of a new start bit SHALL also clear resp_rdy.
REQ-031 The transmitter and receiver SHALL operate independently, allowing full duplex.

Reset
REQ-032 While rst_n is 0 at a clk edge: TX=1, cmd_sent=0, resp_rdy=0, resp=0x00, sequencer in IDLE, receiver idle, all baud and bit counters cleared.
REQ-033 Reset asserted mid-frame SHALL abort the transmission and reception immediately.
REQ-034 After reset, TX SHALL stay high until the next send_cmd.

Verification (BAUD_DIV=16 for the bench)
REQ-035 Reset, then hold idle 100 cycles -> TX=1, cmd_sent=0, resp_rdy=0, resp=0x00.
REQ-036 send_cmd with cmd=0x05, data=0x00FF -> a loopback UART decodes 0x05, 0x00, 0xFF in order; cmd_sent rises 480+-2 clocks after send_cmd and stays high.
REQ-037 send_cmd with cmd=0x02, data=0x0100, then change data to 0xFFFF and pulse send_cmd again mid-frame -> bytes 0x02, 0x01, 0x00 only; the second pulse is ignored.
REQ-038 Drive RX with frame 0xA5 -> resp=0xA5 and resp_rdy=1 at the end of the frame; pulse clr_resp_rdy -> resp_rdy=0 and resp stays 0xA5.
REQ-039 Send command 0x06 while RX simultaneously receives 0x0A -> TX bytes are correct and resp=0x0A, confirming full-duplex operation.
REQ-040 Assert rst_n=0 mid-way through the HIGH byte -> TX=1 on the next edge, cmd_sent=0, and no further bytes are emitted.
